// File: rtl/serdes_pll_reconfig_pkg.sv
// Shared types and constants for the PLL reconfiguration sequencer.
package serdes_pll_reconfig_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WR,
    S_CRD,
    S_CWR,
    S_WCAL,
    S_WLOCK,
    S_RSP
  } state_t;

  localparam logic [1:0] ST_OK      = 2'd0;
  localparam logic [1:0] ST_CAL_TO  = 2'd1;
  localparam logic [1:0] ST_LOCK_TO = 2'd2;
  localparam logic [1:0] ST_BAD_IDX = 2'd3;

  localparam int DEF_CAL_ADDR = 'h100;
  localparam int DEF_CAL_BIT  = 1;

endpackage

// File: rtl/serdes_avmm_rmw.sv
// Single-port Avalon-MM access engine: raises a strobe on request and
// holds it until waitrequest is seen low.
module serdes_avmm_rmw #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_go,
  input  logic              wr_go,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              waitrequest,
  output logic              rd,
  output logic              wr,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] writedata,
  output logic              done
);

  assign done = (rd | wr) & ~waitrequest;

  // A new request in the completing cycle overrides the drop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd        <= 1'b0;
      wr        <= 1'b0;
      address   <= '0;
      writedata <= '0;
    end else begin
      if (done) begin
        rd <= 1'b0;
        wr <= 1'b0;
      end
      if (rd_go) begin
        rd      <= 1'b1;
        address <= addr;
      end
      if (wr_go) begin
        wr        <= 1'b1;
        address   <= addr;
        writedata <= wdata;
      end
    end
  end

endmodule

// File: rtl/serdes_pll_reconfig_ctrl.sv
// Multi-PLL reconfig sequencer: register read-modify-write, optional
// recalibration, then cal-done and lock waits with timeouts.
module serdes_pll_reconfig_ctrl
  import serdes_pll_reconfig_pkg::*;
#(
  parameter int                N_PLL    = 2,
  parameter int                ADDR_W   = 10,
  parameter int                DATA_W   = 32,
  parameter logic [ADDR_W-1:0] CAL_ADDR = ADDR_W'(DEF_CAL_ADDR),
  parameter int                CAL_BIT  = DEF_CAL_BIT,
  parameter int                TIMEOUT  = 1_000_000
) (
  input  logic                    reconfig_clk,
  input  logic                    reconfig_rst_n,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [2:0]              cmd_pll,
  input  logic [ADDR_W-1:0]       cmd_addr,
  input  logic [DATA_W-1:0]       cmd_mask,
  input  logic [DATA_W-1:0]       cmd_data,
  input  logic                    cmd_recal,
  output logic                    rsp_valid,
  output logic [1:0]              rsp_status,
  output logic [DATA_W-1:0]       rsp_rdata,
  output logic [N_PLL-1:0]        reconfig_write,
  output logic [N_PLL-1:0]        reconfig_read,
  output logic [ADDR_W-1:0]       reconfig_address,
  output logic [DATA_W-1:0]       reconfig_writedata,
  input  logic [N_PLL*DATA_W-1:0] reconfig_readdata,
  input  logic [N_PLL-1:0]        reconfig_waitrequest,
  input  logic [N_PLL-1:0]        pll_cal_busy,
  input  logic [N_PLL-1:0]        pll_locked,
  output logic                    locked_all
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);
  localparam logic [DATA_W-1:0] CAL_M = DATA_W'(1) << CAL_BIT;

  state_t              state;
  logic [2:0]          pll_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   mask_q;
  logic [DATA_W-1:0]   data_q;
  logic                recal_q;
  logic [TW-1:0]       timer;
  logic                idle_seen;
  logic [N_PLL-1:0]    busy_m, busy_s, lock_m, lock_s;
  logic [DATA_W-1:0]   sel_rdata;
  logic                sel_wait, sel_busy, sel_lock;
  logic                rd_go, wr_go, rd, wr, done;
  logic [ADDR_W-1:0]   go_addr;
  logic [DATA_W-1:0]   go_wdata;
  logic                accept, bad;

  assign accept = cmd_valid & cmd_ready;
  assign bad    = int'(cmd_pll) >= N_PLL;

  always_ff @(posedge reconfig_clk or negedge reconfig_rst_n) begin
    if (!reconfig_rst_n) begin
      busy_m <= '0;
      busy_s <= '0;
      lock_m <= '0;
      lock_s <= '0;
    end else begin
      busy_m <= pll_cal_busy;
      busy_s <= busy_m;
      lock_m <= pll_locked;
      lock_s <= lock_m;
    end
  end

  assign locked_all = &lock_s;

  always_comb begin
    sel_rdata = '0;
    sel_wait  = 1'b1;
    sel_busy  = 1'b1;
    sel_lock  = 1'b0;
    for (int i = 0; i < N_PLL; i++) begin
      if (pll_q == 3'(i)) begin
        sel_rdata = reconfig_readdata[i*DATA_W +: DATA_W];
        sel_wait  = reconfig_waitrequest[i];
        sel_busy  = busy_s[i];
        sel_lock  = lock_s[i];
      end
    end
  end

  always_comb begin
    rd_go    = 1'b0;
    wr_go    = 1'b0;
    go_addr  = addr_q;
    go_wdata = '0;
    unique case (state)
      S_IDLE: if (accept && !bad) begin
        rd_go   = 1'b1;
        go_addr = cmd_addr;
      end
      S_RD: if (done) begin
        if (mask_q != '0) begin
          wr_go    = 1'b1;
          go_wdata = (sel_rdata & ~mask_q) | (data_q & mask_q);
        end else if (recal_q) begin
          rd_go   = 1'b1;
          go_addr = CAL_ADDR;
        end
      end
      S_WR: if (done && recal_q) begin
        rd_go   = 1'b1;
        go_addr = CAL_ADDR;
      end
      S_CRD: if (done) begin
        wr_go    = 1'b1;
        go_addr  = CAL_ADDR;
        go_wdata = sel_rdata | CAL_M;
      end
      default: ;
    endcase
  end

  serdes_avmm_rmw #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_rmw (
    .clk        (reconfig_clk),
    .rst_n      (reconfig_rst_n),
    .rd_go      (rd_go),
    .wr_go      (wr_go),
    .addr       (go_addr),
    .wdata      (go_wdata),
    .waitrequest(sel_wait),
    .rd         (rd),
    .wr         (wr),
    .address    (reconfig_address),
    .writedata  (reconfig_writedata),
    .done       (done)
  );

  // pll_q is always in range while a strobe is up.
  assign reconfig_read  = rd ? (N_PLL'(1) << pll_q) : '0;
  assign reconfig_write = wr ? (N_PLL'(1) << pll_q) : '0;

  always_ff @(posedge reconfig_clk or negedge reconfig_rst_n) begin
    if (!reconfig_rst_n) begin
      state      <= S_IDLE;
      cmd_ready  <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_status <= ST_OK;
      rsp_rdata  <= '0;
      pll_q      <= '0;
      addr_q     <= '0;
      mask_q     <= '0;
      data_q     <= '0;
      recal_q    <= 1'b0;
      timer      <= '0;
      idle_seen  <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          cmd_ready <= 1'b1;
          if (accept) begin
            cmd_ready <= 1'b0;
            pll_q     <= cmd_pll;
            addr_q    <= cmd_addr;
            mask_q    <= cmd_mask;
            data_q    <= cmd_data;
            recal_q   <= cmd_recal;
            rsp_rdata <= '0;
            if (bad) begin
              state      <= S_RSP;
              rsp_valid  <= 1'b1;
              rsp_status <= ST_BAD_IDX;
            end else begin
              state <= S_RD;
            end
          end
        end
        S_RD: if (done) begin
          rsp_rdata <= sel_rdata;
          if (mask_q != '0) begin
            state <= S_WR;
          end else if (recal_q) begin
            state <= S_CRD;
          end else begin
            state      <= S_RSP;
            rsp_valid  <= 1'b1;
            rsp_status <= ST_OK;
          end
        end
        S_WR: if (done) begin
          if (recal_q) begin
            state <= S_CRD;
          end else begin
            state      <= S_RSP;
            rsp_valid  <= 1'b1;
            rsp_status <= ST_OK;
          end
        end
        S_CRD: if (done) state <= S_CWR;
        S_CWR: if (done) begin
          state     <= S_WCAL;
          timer     <= '0;
          idle_seen <= 1'b0;
        end
        S_WCAL: begin
          idle_seen <= ~sel_busy;
          if (timer != TMAX) timer <= timer + 1'b1;
          if (!sel_busy && idle_seen) begin
            state <= S_WLOCK;
            timer <= '0;
          end else if (timer == TMAX) begin
            state      <= S_RSP;
            rsp_valid  <= 1'b1;
            rsp_status <= ST_CAL_TO;
          end
        end
        S_WLOCK: begin
          if (timer != TMAX) timer <= timer + 1'b1;
          if (sel_lock) begin
            state      <= S_RSP;
            rsp_valid  <= 1'b1;
            rsp_status <= ST_OK;
          end else if (timer == TMAX) begin
            state      <= S_RSP;
            rsp_valid  <= 1'b1;
            rsp_status <= ST_LOCK_TO;
          end
        end
        S_RSP: begin
          rsp_valid <= 1'b0;
          cmd_ready <= 1'b1;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serdes_pll_reconfig_ctrl.sv
// Randomised and directed bench for serdes_pll_reconfig_ctrl with a
// memory-backed Avalon-MM slave and a transaction-level reference model.
module tb_serdes_pll_reconfig_ctrl;
  localparam int NP = 2;
  localparam int TMO = 100;
  localparam logic [9:0] CALA = 10'h100;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic cmd_valid, cmd_ready, cmd_recal;
  logic [2:0] cmd_pll;
  logic [9:0] cmd_addr;
  logic [31:0] cmd_mask, cmd_data;
  logic rsp_valid;
  logic [1:0] rsp_status;
  logic [31:0] rsp_rdata;
  logic [NP-1:0] reconfig_write, reconfig_read;
  logic [9:0] reconfig_address;
  logic [31:0] reconfig_writedata;
  logic [NP*32-1:0] reconfig_readdata;
  logic [NP-1:0] reconfig_waitrequest, pll_cal_busy, pll_locked;
  logic locked_all;

  serdes_pll_reconfig_ctrl #(.N_PLL(NP), .TIMEOUT(TMO)) dut (
    .reconfig_clk(clk), .reconfig_rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_pll(cmd_pll),
    .cmd_addr(cmd_addr), .cmd_mask(cmd_mask), .cmd_data(cmd_data),
    .cmd_recal(cmd_recal), .rsp_valid(rsp_valid),
    .rsp_status(rsp_status), .rsp_rdata(rsp_rdata),
    .reconfig_write(reconfig_write), .reconfig_read(reconfig_read),
    .reconfig_address(reconfig_address),
    .reconfig_writedata(reconfig_writedata),
    .reconfig_readdata(reconfig_readdata),
    .reconfig_waitrequest(reconfig_waitrequest),
    .pll_cal_busy(pll_cal_busy), .pll_locked(pll_locked),
    .locked_all(locked_all));

  int checks = 0;
  int errors = 0;
  logic [31:0] slave_mem [NP][1024];
  logic [31:0] ref_mem [NP][1024];
  typedef struct { int pll; logic [9:0] addr; logic [31:0] data; } wr_t;
  wr_t wq[$];
  int rd_cnt = 0, rd_cyc = 0, wr_cyc = 0;
  int stall_cfg = 0, stall_left = 0;
  logic fresh = 1'b1;

  // Slave: commit accesses on the clock edge, log writes, watch strobes.
  always @(posedge clk) begin
    if (reconfig_read != '0) rd_cyc++;
    if (reconfig_write != '0) wr_cyc++;
    if ((reconfig_read | reconfig_write) != '0) begin
      checks++;
      if ($countones({reconfig_read, reconfig_write}) != 1) begin
        errors++;
        $display("FAIL onehot rd=%b wr=%b required one strobe", reconfig_read, reconfig_write);
      end
    end
    for (int i = 0; i < NP; i++) begin
      if (reconfig_write[i] && !reconfig_waitrequest[i]) begin
        slave_mem[i][reconfig_address] = reconfig_writedata;
        wq.push_back('{i, reconfig_address, reconfig_writedata});
        fresh = 1'b1;
      end
      if (reconfig_read[i] && !reconfig_waitrequest[i]) begin
        rd_cnt++;
        fresh = 1'b1;
      end
    end
  end

  // Slave: present data and stall each new access for stall_cfg cycles.
  always @(negedge clk) begin
    logic act;
    for (int i = 0; i < NP; i++)
      reconfig_readdata[i*32 +: 32] = slave_mem[i][reconfig_address];
    act = (reconfig_read | reconfig_write) != '0;
    if (act && fresh) begin
      stall_left = stall_cfg;
      fresh = 1'b0;
    end
    reconfig_waitrequest = '1;
    if (act) begin
      if (stall_left > 0) stall_left--;
      else reconfig_waitrequest = ~(reconfig_read | reconfig_write);
    end
  end

  initial begin
    #500_000;
    $display("FAIL watchdog expired");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  task automatic send(input logic [2:0] p, input logic [9:0] a,
                      input logic [31:0] m, input logic [31:0] d,
                      input logic r);
    int k = 0;
    @(negedge clk);
    while (!cmd_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL cmd_ready_wait got %b required 1", cmd_ready);
    end
    cmd_valid = 1'b1; cmd_pll = p; cmd_addr = a;
    cmd_mask = m; cmd_data = d; cmd_recal = r;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int budget, output int n);
    n = 0;
    while (rsp_valid !== 1'b1 && n <= budget) begin
      @(posedge clk); #1;
      n++;
    end
    if (rsp_valid !== 1'b1) n = -1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({cmd_ready, rsp_valid, reconfig_read, reconfig_write} !== '0) begin
      errors++;
      $display("FAIL reset_ctl ready=%b rsp=%b rd=%b wr=%b required all 0",
               cmd_ready, rsp_valid, reconfig_read, reconfig_write);
    end
    checks++;
    if (reconfig_address !== '0 || reconfig_writedata !== '0) begin
      errors++;
      $display("FAIL reset_bus addr=%h wdata=%h required 0", reconfig_address, reconfig_writedata);
    end
    checks++;
    if (rsp_status !== 2'd0 || rsp_rdata !== '0 || locked_all !== 1'b0) begin
      errors++;
      $display("FAIL reset_rsp status=%0d rdata=%h lk=%b required 0", rsp_status, rsp_rdata, locked_all);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready got %b required 1", cmd_ready);
    end
  endtask

  task automatic test_basic();
    slave_mem[1][16] = 32'hAABB_CCDD;
    ref_mem[1][16] = 32'hAABB_CCDD;
    stall_cfg = 0;
    wq.delete();
    send(3'd1, 10'h010, 32'h0000_00FF, 32'h55, 1'b0);
    checks++;
    if (reconfig_read !== 2'b10 || reconfig_address !== 10'h010) begin
      errors++;
      $display("FAIL basic_rd rd=%b addr=%h required 10 010", reconfig_read, reconfig_address);
    end
    @(posedge clk); #1;
    checks++;
    if (reconfig_write !== 2'b10 || reconfig_writedata !== 32'hAABB_CC55) begin
      errors++;
      $display("FAIL basic_wr wr=%b wdata=%h required 10 aabbcc55", reconfig_write, reconfig_writedata);
    end
    @(posedge clk); #1;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_status !== 2'd0 || rsp_rdata !== 32'hAABB_CCDD) begin
      errors++;
      $display("FAIL basic_rsp v=%b st=%0d rdata=%h required 1 0 aabbccdd", rsp_valid, rsp_status, rsp_rdata);
    end
    @(posedge clk); #1;
    checks++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL basic_pulse v=%b ready=%b required 0 1", rsp_valid, cmd_ready);
    end
    ref_mem[1][16] = 32'hAABB_CC55;
  endtask

  task automatic test_stall();
    logic [31:0] d = $urandom;
    logic [31:0] nv = (ref_mem[0][9] & 32'h0000_FFFF) | (d & 32'hFFFF_0000);
    int n, extra = 0;
    stall_cfg = 3;
    wq.delete();
    rd_cyc = 0;
    wr_cyc = 0;
    send(3'd0, 10'h009, 32'hFFFF_0000, d, 1'b0);
    cmd_valid = 1'b1; cmd_pll = 3'd1; cmd_addr = 10'h020;
    cmd_mask = '1; cmd_data = '0;
    repeat (3) @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    wait_rsp(40, n);
    if (n >= 0) n += 3;
    checks++;
    if (n != 8 || rsp_status !== 2'd0) begin
      errors++;
      $display("FAIL stall_lat got %0d st=%0d required 8 0", n, rsp_status);
    end
    checks++;
    if (rd_cyc != 4 || wr_cyc != 4) begin
      errors++;
      $display("FAIL stall_hold rd=%0d wr=%0d required 4 4", rd_cyc, wr_cyc);
    end
    repeat (10) begin
      @(posedge clk); #1;
      if (rsp_valid) extra++;
    end
    checks++;
    if (extra != 0 || wq.size() != 1) begin
      errors++;
      $display("FAIL busy_ignore rsp=%0d writes=%0d required 0 1", extra, wq.size());
    end else begin
      checks++;
      if (wq[0].pll != 0 || wq[0].addr !== 10'h009 || wq[0].data !== nv) begin
        errors++;
        $display("FAIL stall_wdata got %0d %h %h required 0 009 %h", wq[0].pll, wq[0].addr, wq[0].data, nv);
      end
    end
    ref_mem[0][9] = nv;
    stall_cfg = 0;
  endtask

  task automatic test_random();
    for (int t = 0; t < 30; t++) begin
      logic [2:0] p;
      logic [9:0] a;
      logic [31:0] m, d, old, nv;
      int s, n, nexp;
      logic bad;
      p = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(2, 7)) : 3'($urandom_range(0, 1));
      a = ($urandom_range(0, 7) == 0) ? CALA : 10'($urandom_range(0, 15));
      m = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      d = $urandom;
      s = $urandom_range(0, 3);
      bad = p >= 3'(NP);
      old = bad ? 32'd0 : ref_mem[p][a];
      nv = (old & ~m) | (d & m);
      nexp = bad ? 0 : (1 + s) * ((m != 0) ? 2 : 1);
      stall_cfg = s;
      wq.delete();
      rd_cnt = 0;
      send(p, a, m, d, 1'b0);
      wait_rsp(40, n);
      checks++;
      if (n != nexp || rsp_status !== (bad ? 2'd3 : 2'd0)) begin
        errors++;
        $display("FAIL rand_rsp[%0d] lat=%0d st=%0d required %0d %0d", t, n, rsp_status, nexp, bad ? 3 : 0);
      end
      if (!bad) begin
        checks++;
        if (rsp_rdata !== old) begin
          errors++;
          $display("FAIL rand_rdata[%0d] got %h required %h", t, rsp_rdata, old);
        end
      end
      @(posedge clk); #1;
      checks++;
      if (rsp_valid !== 1'b0 || rd_cnt != (bad ? 0 : 1)) begin
        errors++;
        $display("FAIL rand_pulse[%0d] v=%b reads=%0d", t, rsp_valid, rd_cnt);
      end
      checks++;
      if (wq.size() != ((!bad && m != 0) ? 1 : 0)) begin
        errors++;
        $display("FAIL rand_nwr[%0d] got %0d", t, wq.size());
      end else if (wq.size() == 1) begin
        checks++;
        if (wq[0].pll != int'(p) || wq[0].addr !== a || wq[0].data !== nv) begin
          errors++;
          $display("FAIL rand_wr[%0d] got %0d %h %h required %0d %h %h", t, wq[0].pll, wq[0].addr, wq[0].data, p, a, nv);
        end
      end
      if (!bad && m != 0) ref_mem[p][a] = nv;
    end
    stall_cfg = 0;
  endtask

  task automatic test_bad_index();
    logic [2:0] idx [2] = '{3'd2, 3'd7};
    foreach (idx[j]) begin
      int n;
      wq.delete();
      rd_cyc = 0;
      wr_cyc = 0;
      send(idx[j], 10'h001, '1, '1, 1'b1);
      wait_rsp(10, n);
      checks++;
      if (n != 0 || rsp_status !== 2'd3) begin
        errors++;
        $display("FAIL bad_idx[%0d] lat=%0d st=%0d required 0 3", idx[j], n, rsp_status);
      end
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (rd_cyc != 0 || wr_cyc != 0 || wq.size() != 0) begin
        errors++;
        $display("FAIL bad_bus[%0d] rd=%0d wr=%0d required 0 0", idx[j], rd_cyc, wr_cyc);
      end
    end
  endtask

  task automatic test_locked_all();
    @(negedge clk);
    pll_locked = 2'b11;
    @(posedge clk); #1;
    checks++;
    if (locked_all !== 1'b0) begin
      errors++;
      $display("FAIL lk_lag1 got %b required 0", locked_all);
    end
    @(posedge clk); #1;
    checks++;
    if (locked_all !== 1'b1) begin
      errors++;
      $display("FAIL lk_lag2 got %b required 1", locked_all);
    end
    @(negedge clk);
    pll_locked = 2'b01;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (locked_all !== 1'b0) begin
      errors++;
      $display("FAIL lk_drop got %b required 0", locked_all);
    end
  endtask

  task automatic test_recal();
    logic [31:0] d = $urandom;
    logic [31:0] old = ref_mem[0][5];
    logic [31:0] nv = (old & ~32'h0F0F) | (d & 32'h0F0F);
    logic [31:0] cv = ref_mem[0][CALA] | 32'h2;
    int n = 0;
    pll_cal_busy[0] = 1'b1;
    pll_locked[0] = 1'b0;
    repeat (3) @(posedge clk);
    wq.delete();
    send(3'd0, 10'h005, 32'h0F0F, d, 1'b1);
    while (n < 150 && rsp_valid !== 1'b1) begin
      @(posedge clk); #1;
      n++;
      if (n == 50) pll_cal_busy[0] = 1'b0;
      if (n == 70) pll_locked[0] = 1'b1;
    end
    checks++;
    if (rsp_valid !== 1'b1 || rsp_status !== 2'd0 || n < 72 || n > 76) begin
      errors++;
      $display("FAIL recal_rsp v=%b st=%0d lat=%0d required 1 0 72..76", rsp_valid, rsp_status, n);
    end
    checks++;
    if (rsp_rdata !== old) begin
      errors++;
      $display("FAIL recal_rdata got %h required %h", rsp_rdata, old);
    end
    checks++;
    if (wq.size() != 2) begin
      errors++;
      $display("FAIL recal_nwr got %0d required 2", wq.size());
    end else if (wq[0].addr !== 10'h005 || wq[0].data !== nv ||
                 wq[1].addr !== CALA || wq[1].data !== cv || wq[1].pll != 0) begin
      errors++;
      $display("FAIL recal_wr got %h=%h %h=%h required 005=%h 100=%h", wq[0].addr, wq[0].data, wq[1].addr, wq[1].data, nv, cv);
    end
    ref_mem[0][5] = nv;
    ref_mem[0][CALA] = cv;
  endtask

  task automatic test_timeout(input logic busy, input logic [1:0] st);
    logic [31:0] old = ref_mem[1][3];
    logic [31:0] cv = ref_mem[1][CALA] | 32'h2;
    int n;
    pll_cal_busy[1] = busy;
    pll_locked[1] = 1'b0;
    repeat (3) @(posedge clk);
    wq.delete();
    send(3'd1, 10'h003, 32'd0, 32'd0, 1'b1);
    wait_rsp(300, n);
    checks++;
    if (rsp_status !== st || n < TMO || n > TMO + 10) begin
      errors++;
      $display("FAIL timeout_%0d st=%0d lat=%0d required %0d %0d..%0d", st, rsp_status, n, st, TMO, TMO + 10);
    end
    checks++;
    if (rsp_rdata !== old || wq.size() != 1) begin
      errors++;
      $display("FAIL timeout_bus_%0d rdata=%h nwr=%0d required %h 1", st, rsp_rdata, wq.size(), old);
    end else if (wq[0].addr !== CALA || wq[0].data !== cv) begin
      errors++;
      $display("FAIL timeout_cal_%0d got %h=%h required 100=%h", st, wq[0].addr, wq[0].data, cv);
    end
    ref_mem[1][CALA] = cv;
  endtask

  task automatic test_reset_mid();
    int k = 0, extra = 0;
    stall_cfg = 5;
    wq.delete();
    send(3'd1, 10'h007, 32'h1, 32'h1, 1'b0);
    while (reconfig_write === '0 && k < 30) begin
      @(posedge clk); #1;
      k++;
    end
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (reconfig_write !== '0 || reconfig_read !== '0 || cmd_ready !== 1'b0 || k >= 30) begin
      errors++;
      $display("FAIL rst_mid wr=%b rd=%b ready=%b wait=%0d required 0 0 0", reconfig_write, reconfig_read, cmd_ready, k);
    end
    @(negedge clk);
    rst_n = 1'b1;
    fresh = 1'b1;
    stall_left = 0;
    stall_cfg = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (rsp_valid) extra++;
    end
    checks++;
    if (extra != 0 || cmd_ready !== 1'b1 || wq.size() != 0) begin
      errors++;
      $display("FAIL rst_after rsp=%0d ready=%b nwr=%0d required 0 1 0", extra, cmd_ready, wq.size());
    end
  endtask

  initial begin
    for (int i = 0; i < NP; i++)
      for (int j = 0; j < 1024; j++) begin
        slave_mem[i][j] = $urandom;
        ref_mem[i][j] = slave_mem[i][j];
      end
    rst_n = 1'b0;
    cmd_valid = 1'b0; cmd_pll = '0; cmd_addr = '0;
    cmd_mask = '0; cmd_data = '0; cmd_recal = 1'b0;
    reconfig_waitrequest = '1;
    reconfig_readdata = '0;
    pll_cal_busy = '0;
    pll_locked = '0;
    test_reset();
    test_basic();
    test_stall();
    test_random();
    test_bad_index();
    test_locked_all();
    test_recal();
    test_timeout(1'b1, 2'd1);
    test_timeout(1'b0, 2'd2);
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
